regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parameterised multi-port register file for the next datapath revision: 2 write ports (ALU result, load/writeback), 3 asynchronous read ports (Rn, Rm, store-data Rt).
- Integrated pending-write scoreboard so decode can detect read-after-write hazards on long-latency producers.
- Hard-wired zero register at a configurable index.
- Sits between decode (read/allocate) and writeback (write/clear).

Parameters:
- DATA_W, 64, register width in bits.
- ADDR_W, 5, register index width.
- DEPTH, 32, number of registers; must be <= 2**ADDR_W.
- ZERO_REG, 31, index that always reads 0; writes to it are discarded; its busy bit is never set.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous active-low reset.
- rd_addr_a  in  ADDR_W  read port A index (Rn).
- rd_addr_b  in  ADDR_W  read port B index (Rm).
- rd_addr_c  in  ADDR_W  read port C index (Rt, store data).
- rd_data_a / rd_data_b / rd_data_c  out  DATA_W  read data, combinational.
- rd_busy_a / rd_busy_b / rd_busy_c  out  1  scoreboard bit of the addressed register, combinational.
- wr0_en  in  1  write port 0 enable (ALU).
- wr0_addr  in  ADDR_W  write port 0 index.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 enable (load/writeback).
- wr1_addr  in  ADDR_W  write port 1 index.
- wr1_data  in  DATA_W  write port 1 data.
- alloc_en  in  1  mark a destination as pending.
- alloc_addr  in  ADDR_W  index to mark pending.
- any_busy  out  1  OR of all busy bits (drain/flush indicator).

Behaviour:
- Reset:
  - On rising CLK with RST_N=0, all DEPTH registers become 0 and all busy bits become 0; any_busy=0 the next cycle.
  - Reset overrides writes and allocation in the same cycle.
  - Reads remain combinational during reset and return the pre-edge state until the edge.
- Reads:
  - rd_data_x = reg[rd_addr_x].
  - rd_addr_x == ZERO_REG or rd_addr_x >= DEPTH -> data 0, busy 0.
  - Read latency is 0 cycles.
- Writes:
  - On rising edge, wrN_en=1 and wrN_addr != ZERO_REG and wrN_addr < DEPTH -> reg[wrN_addr] <= wrN_data.
  - Both ports writing the same address in the same cycle: port 1 (load) wins.
  - Writes to ZERO_REG or an out-of-range index have no effect on data or busy state.
- Scoreboard, per register i, evaluated on each rising edge:
  - Clear when (wr0_en and wr0_addr==i) or (wr1_en and wr1_addr==i).
  - Set when alloc_en and alloc_addr==i.
  - Set and clear in the same cycle: set wins, because the allocation belongs to a younger producer.
  - alloc to ZERO_REG or an out-of-range index is ignored.
  - Re-allocating an already-busy register keeps it busy.
  - A write to a register that is not busy is legal and leaves it not busy.
- any_busy is registered-state derived: combinational OR of the busy flops, no extra latency.
- No internal FSM beyond the per-register busy flops; the write/clear/alloc priority above is the complete state transition table.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding. If a read address matches an enabled, valid write in the same cycle, rd_data returns that write data (port 1 priority over port 0), and rd_busy returns the post-edge value (0 unless a same-cycle alloc targets it).
  - Zero-cycle producer-to-consumer.
- Undefined:
  - Reads return the stored value only; written data becomes visible the cycle after the write edge.
  - rd_busy reflects current flop state.

Test Plan:
- Reset clear: preload reg5=0xDEAD, busy5=1; RST_N=0 for one edge -> rd_data_a(5)=0, rd_busy_a=0, any_busy=0.
- Zero register: wr0 to 31 with 0xFFFF_FFFF_FFFF_FFFF, alloc 31 -> rd_data_b(31)=0, rd_busy_b=0, any_busy unchanged.
- Dual-write collision: wr0 (7, 0x11) and wr1 (7, 0x22) on the same edge -> reg7=0x22 next cycle; also wr0 (3, 0xA), wr1 (4, 0xB) -> reg3=0xA, reg4=0xB.
- Scoreboard priority:
  - alloc 9 -> busy9=1.
  - Then wr1 9 with alloc 9 on the same edge -> busy9=1, reg9 updated.
  - Then wr1 9 alone -> busy9=0, any_busy=0.
- Bypass, with REGFILE_BYPASS_EN: wr0 (12, 0x1234) and rd_addr_c=12 in the same cycle -> rd_data_c=0x1234 before the edge. Without the macro: old value before the edge, 0x1234 after.
- Reset mid-operation: alloc 2 and wr0 (2, 0x55) with RST_N=0 on the same edge -> reg2=0, busy2=0.

Source files
------------

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_mp                                                   |
// | Description : 2-write / 3-read register file with pending-write scoreboard |
// |               and a hard-wired zero register. REGFILE_BYPASS_EN enables     |
// |               same-cycle write-through forwarding on the read ports.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module regfile_mp #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 31
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] rd_addr_c,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] rd_data_c,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    output logic              rd_busy_c,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_addr,
    output logic              any_busy
);

    localparam logic [ADDR_W-1:0] c_ZERO  = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    logic w_wr0Ok;
    logic w_wr1Ok;
    logic w_allocOk;

    function automatic logic addrOk(input logic [ADDR_W-1:0] addr);
        return (addr != c_ZERO) && ({1'b0, addr} < c_DEPTH);
    endfunction

    assign w_wr0Ok   = wr0_en   && addrOk(wr0_addr);
    assign w_wr1Ok   = wr1_en   && addrOk(wr1_addr);
    assign w_allocOk = alloc_en && addrOk(alloc_addr);

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr0Ok) r_regs[wr0_addr] <= wr0_data;
            if (w_wr1Ok) r_regs[wr1_addr] <= wr1_data;
        end
    end

    // Allocation beats a same-cycle clear: it belongs to a younger producer.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_allocOk && alloc_addr == ADDR_W'(i)) begin
                    r_busy[i] <= 1'b1;
                end else if ((w_wr0Ok && wr0_addr == ADDR_W'(i)) ||
                             (w_wr1Ok && wr1_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] readData(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        v = '0;
        if (addrOk(addr)) begin
            v = r_regs[addr];
`ifdef REGFILE_BYPASS_EN
            if (w_wr1Ok && wr1_addr == addr) begin
                v = wr1_data;
            end else if (w_wr0Ok && wr0_addr == addr) begin
                v = wr0_data;
            end
`endif
        end
        return v;
    endfunction

    function automatic logic readBusy(input logic [ADDR_W-1:0] addr);
        logic v;
        v = 1'b0;
        if (addrOk(addr)) begin
            v = r_busy[addr];
`ifdef REGFILE_BYPASS_EN
            if ((w_wr0Ok && wr0_addr == addr) || (w_wr1Ok && wr1_addr == addr)) begin
                v = w_allocOk && (alloc_addr == addr);
            end
`endif
        end
        return v;
    endfunction

    always_comb begin
        rd_data_a = readData(rd_addr_a);
        rd_data_b = readData(rd_addr_b);
        rd_data_c = readData(rd_addr_c);
        rd_busy_a = readBusy(rd_addr_a);
        rd_busy_b = readBusy(rd_addr_b);
        rd_busy_c = readBusy(rd_addr_c);
    end

    assign any_busy = |r_busy;

endmodule
`default_nettype wire
